dcache_core: RTL and testbench

Direct-mapped, write-back, write-allocate data cache sitting between the load/store request source (the data-cache stimulus generator in test, the MEM stage in the core) and main memory. It accepts one word request per cycle on hits. On a miss it raises `requested_data_to_mem` to stall the requester while it writes back a dirty victim and fills the line with a single-beat 128-bit transfer. A `flush` request writes back every dirty line and invalidates the array.

---
 rtl/dcache_pkg.sv | 16 +
 rtl/dcache_array.sv | 32 +++
 rtl/dcache_core.sv | 153 +++++++++++++++
 tb/tb_dcache_core.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and field widths for the direct-mapped data cache
package dcache_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_FLUSH_SCAN, S_FLUSH_WB} dc_state_t;
  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int TAG_W = 28;
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction
  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } line_t;
endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag/valid/dirty/data storage with combinational read and word/line writes
module dcache_array import dcache_pkg::*; #(
  parameter int LINES = 4,
  parameter int WORDS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [idx_w(LINES)-1:0]    i_idx,
  output line_t                      o_line,
  input  logic                       i_word_we,
  input  logic [$clog2(WORDS)-1:0]   i_off,
  input  logic [WORD_W-1:0]          i_word,
  input  logic                       i_line_we,
  input  line_t                      i_line
);
  line_t r_mem [LINES];
  assign o_line = r_mem[i_idx];
  // line write takes priority; a word write marks the line dirty
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        r_mem[i].valid <= 1'b0;
        r_mem[i].dirty <= 1'b0;
      end
    end else if (i_line_we) begin
      r_mem[i_idx] <= i_line;
    end else if (i_word_we) begin
      r_mem[i_idx].data[{i_off, 5'b0} +: WORD_W] <= i_word;
      r_mem[i_idx].dirty <= 1'b1;
    end
  end
endmodule

// File: rtl/dcache_core.sv
// dcache_core: direct-mapped write-back write-allocate data cache with flush
module dcache_core import dcache_pkg::*; #(
  parameter int LINES = 4,
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              requested_data_to_mem,
  output logic              mm_req,
  output logic              mm_we,
  output logic [31:0]       mm_addr,
  output logic [LINE_W-1:0] mm_wdata,
  input  logic [LINE_W-1:0] mm_rdata,
  input  logic              mm_ready
);
  localparam int IDX = idx_w(LINES);
  localparam int OFF_W = $clog2(WORDS);
  dc_state_t r_state;
  logic r_req_we, r_replay, r_flush_pend, r_stall, r_mm_req, r_mm_we;
  logic [31:0] r_req_addr, r_req_wdata, r_readdata, r_mm_addr;
  logic [LINE_W-1:0] r_mm_wdata, w_fill;
  logic [IDX-1:0] r_scan_idx, w_idx;
  logic [OFF_W-1:0] w_off;
  logic [TAG_W-1:0] w_tag;
  logic [31:0] w_addr, w_victim, w_fill_addr;
  logic w_idle, w_flushing, w_req, w_do_flush, w_hit, w_dv, w_rdy, w_last, w_flush_done;
  logic w_line_we, w_word_we, w_unused;
  line_t w_rd, w_line;
  assign w_idle = r_state == S_IDLE;
  assign w_flushing = r_state == S_FLUSH_SCAN || r_state == S_FLUSH_WB;
  assign w_req = mem_read | mem_write;
  assign w_do_flush = flush | r_flush_pend;
  assign w_addr = w_idle ? address : r_req_addr;
  assign w_idx = w_flushing ? r_scan_idx : w_addr[4 +: IDX];
  assign w_off = w_addr[2 +: OFF_W];
  assign w_tag = TAG_W'(w_addr >> (4 + IDX));
  assign w_hit = w_rd.valid && w_rd.tag == w_tag;
  assign w_dv = w_rd.valid && w_rd.dirty;
  assign w_rdy = mm_ready & r_mm_req;
  assign w_last = r_scan_idx == IDX'(LINES - 1);
  assign w_victim = (32'(w_rd.tag) << (4 + IDX)) | (32'(w_idx) << 4);
  assign w_fill_addr = {w_addr[31:4], 4'b0};
  assign w_flush_done = w_last && ((r_state == S_FLUSH_SCAN && !w_dv) || (r_state == S_FLUSH_WB && w_rdy));
  assign w_line_we = (w_rdy && (r_state == S_FILL || r_state == S_FLUSH_WB)) || (r_state == S_FLUSH_SCAN && !w_dv);
  assign w_word_we = w_idle && !w_do_flush && mem_write && w_hit;
  assign w_unused = ^w_addr[1:0];
  // fill line with the pending store merged in; any other line write invalidates
  always_comb begin
    w_fill = mm_rdata;
    if (r_req_we) w_fill[{w_off, 5'b0} +: WORD_W] = r_req_wdata;
    w_line = '0;
    w_line.valid = r_state == S_FILL;
    w_line.dirty = r_state == S_FILL && r_req_we;
    w_line.tag = r_state == S_FILL ? w_tag : '0;
    w_line.data = r_state == S_FILL ? w_fill : '0;
  end
  dcache_array #(.LINES(LINES), .WORDS(WORDS)) u_array (
    .clk(clk), .reset(reset), .i_idx(w_idx), .o_line(w_rd),
    .i_word_we(w_word_we), .i_off(w_off), .i_word(writedata),
    .i_line_we(w_line_we), .i_line(w_line)
  );
  // control FSM with registered stall and memory-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_readdata <= '0;
      r_stall <= 1'b0;
      r_mm_req <= 1'b0;
      r_mm_we <= 1'b0;
      r_mm_addr <= '0;
      r_mm_wdata <= '0;
      r_flush_pend <= 1'b0;
      r_replay <= 1'b0;
      r_req_we <= 1'b0;
      r_req_addr <= '0;
      r_req_wdata <= '0;
      r_scan_idx <= '0;
    end else begin
      if (flush && !w_idle) r_flush_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_do_flush || (w_req && !w_hit)) begin
            r_req_we <= mem_write;
            r_req_addr <= address;
            r_req_wdata <= writedata;
          end
          if (w_do_flush) begin
            r_state <= S_FLUSH_SCAN;
            r_stall <= 1'b1;
            r_flush_pend <= 1'b0;
            r_scan_idx <= '0;
            r_replay <= w_req;
          end else if (w_req && w_hit) begin
            if (!mem_write) r_readdata <= w_rd.data[{w_off, 5'b0} +: WORD_W];
          end else if (w_req) begin
            r_state <= w_dv ? S_WB : S_FILL;
            r_stall <= 1'b1;
            r_mm_req <= 1'b1;
            r_mm_we <= w_dv;
            r_mm_addr <= w_dv ? w_victim : w_fill_addr;
            r_mm_wdata <= w_rd.data;
          end
        end
        S_WB: if (w_rdy) begin
          r_state <= S_FILL;
          r_mm_we <= 1'b0;
          r_mm_addr <= w_fill_addr;
        end
        S_FILL: if (w_rdy) begin
          r_state <= S_IDLE;
          r_stall <= 1'b0;
          r_mm_req <= 1'b0;
          if (!r_req_we) r_readdata <= w_fill[{w_off, 5'b0} +: WORD_W];
        end
        S_FLUSH_SCAN: if (w_dv) begin
          r_state <= S_FLUSH_WB;
          r_mm_req <= 1'b1;
          r_mm_we <= 1'b1;
          r_mm_addr <= w_victim;
          r_mm_wdata <= w_rd.data;
        end else begin
          r_scan_idx <= r_scan_idx + 1'b1;
        end
        S_FLUSH_WB: if (w_rdy) begin
          r_state <= S_FLUSH_SCAN;
          r_mm_req <= 1'b0;
          r_scan_idx <= r_scan_idx + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_flush_done) begin
        r_state <= r_replay ? S_FILL : S_IDLE;
        r_stall <= r_replay;
        r_mm_req <= r_replay;
        r_mm_we <= 1'b0;
        r_mm_addr <= w_fill_addr;
        r_replay <= 1'b0;
      end
    end
  end
  assign readdata = r_readdata;
  assign requested_data_to_mem = r_stall;
  assign mm_req = r_mm_req;
  assign mm_we = r_mm_we;
  assign mm_addr = r_mm_addr;
  assign mm_wdata = r_mm_wdata;
endmodule

// File: tb/tb_dcache_core.sv
// tb_dcache_core: directed scoreboard bench for dcache_core with a latency-2 memory model
module tb_dcache_core;
  localparam int LAT = 2;
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] w0;} mm_t;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] address = '0, writedata = '0, readdata, mm_addr;
  logic requested_data_to_mem, mm_req, mm_we;
  logic [127:0] mm_wdata, mm_rdata = '0;
  logic mm_ready = 1'b0;
  int checks = 0, errors = 0, lat = 0, st = 0;
  mm_t exp_mm[$];
  mm_t cur;
  logic [31:0] exp_rd[$];
  logic [127:0] mem [logic [31:0]];

  dcache_core #(.LINES(4), .WORDS(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .requested_data_to_mem(requested_data_to_mem), .mm_req(mm_req), .mm_we(mm_we),
    .mm_addr(mm_addr), .mm_wdata(mm_wdata), .mm_rdata(mm_rdata), .mm_ready(mm_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : {a + 32'd4, a + 32'd3, a + 32'd2, a + 32'd1};
  endfunction

  task automatic exp_m(input logic we, input logic [31:0] a, input logic [31:0] w0);
    exp_mm.push_back('{we, a, w0});
  endtask

  // memory: completes each request LAT negedges after it is seen, checking it against the scoreboard
  always @(negedge clk) begin
    if (reset || mm_ready) begin
      mm_ready = 1'b0;
      lat = 0;
    end else if (mm_req) begin
      if (lat < LAT) lat++;
      else begin
        if (exp_mm.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL mm_unexpected observed we=%0b addr=%0h expected none", mm_we, mm_addr);
        end else begin
          cur = exp_mm.pop_front();
          chk("mm_we", 128'(mm_we), 128'(cur.we));
          chk("mm_addr", 128'(mm_addr), 128'(cur.addr));
          if (cur.we) chk("mm_wdata0", 128'(mm_wdata[31:0]), 128'(cur.w0));
        end
        if (mm_we) mem[mm_addr] = mm_wdata;
        else mm_rdata = mem_line(mm_addr);
        mm_ready = 1'b1;
        lat = 0;
      end
    end
  end

  // issue one request (optionally with flush) and wait for the stall to clear
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic fl, input logic [31:0] exp, output int stalls);
    mem_read = rd; mem_write = wr; address = a; writedata = wd; flush = fl;
    if (rd && !wr) exp_rd.push_back(exp);
    stalls = 0;
    @(posedge clk); #1;
    flush = 1'b0;
    while (requested_data_to_mem && stalls < 300) begin
      stalls++;
      @(posedge clk); #1;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    if (requested_data_to_mem) begin
      checks++;
      errors++;
      $error("FAIL timeout observed stall=1 expected 0 addr=%0h", a);
    end else if (rd && !wr) chk("readdata", 128'(readdata), 128'(exp_rd.pop_front()));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readdata", 128'(readdata), 0);
    chk("rst_stall", 128'(requested_data_to_mem), 0);
    chk("rst_mm_req", 128'(mm_req), 0);
    chk("rst_mm_we", 128'(mm_we), 0);
    chk("rst_mm_addr", 128'(mm_addr), 0);
    chk("rst_mm_wdata", mm_wdata, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    exp_m(0, 32'h00, 0);
    do_req(1, 0, 32'h00, 0, 0, 32'd1, st);
    chk("miss_stalls", 128'(st > 0), 1);
    do_req(1, 0, 32'h04, 0, 0, 32'd2, st);
    chk("hit_nostall", 128'(st), 0);
    exp_m(0, 32'h50, 0);
    do_req(0, 1, 32'h50, 32'd1, 0, 0, st);
    do_req(1, 0, 32'h50, 0, 0, 32'd1, st);
    chk("store_hit_nostall", 128'(st), 0);
    do_req(1, 0, 32'h54, 0, 0, 32'h52, st);
    exp_m(1, 32'h50, 32'd1);
    exp_m(0, 32'h150, 0);
    do_req(1, 0, 32'h150, 0, 0, 32'h151, st);
    exp_m(0, 32'h10, 0);
    do_req(0, 1, 32'h10, 32'hAA, 0, 0, st);
    exp_m(0, 32'h30, 0);
    do_req(0, 1, 32'h30, 32'hBB, 0, 0, st);
    exp_m(1, 32'h10, 32'hAA);
    exp_m(1, 32'h30, 32'hBB);
    do_req(0, 0, 0, 0, 1, 0, st);
    chk("flush_stalls", 128'(st > 0), 1);
    chk("flush_wb_done", 128'(exp_mm.size()), 0);
    exp_m(0, 32'h00, 0);
    do_req(1, 0, 32'h00, 0, 0, 32'd1, st);
    chk("post_flush_miss", 128'(st > 0), 1);
    exp_m(0, 32'h10, 0);
    do_req(1, 0, 32'h10, 0, 0, 32'hAA, st);
    exp_m(0, 32'h20, 0);
    do_req(0, 1, 32'h20, 32'hCC, 0, 0, st);
    exp_m(0, 32'h70, 0);
    mem_read = 1'b1; address = 32'h70; exp_rd.push_back(32'h71);
    @(posedge clk); #1;
    chk("fill_stall", 128'(requested_data_to_mem), 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    st = 0;
    while (requested_data_to_mem && st < 300) begin
      st++;
      @(posedge clk); #1;
    end
    mem_read = 1'b0;
    chk("fill_flush_stall_drop", 128'(requested_data_to_mem), 0);
    chk("fill_flush_readdata", 128'(readdata), 128'(exp_rd.pop_front()));
    exp_m(1, 32'h20, 32'hCC);
    exp_m(0, 32'h00, 0);
    do_req(1, 0, 32'h04, 0, 0, 32'd2, st);
    chk("replay_stalls", 128'(st > 0), 1);
    exp_m(0, 32'h40, 0);
    do_req(0, 1, 32'h40, 32'hDD, 0, 0, st);
    mem_read = 1'b1; address = 32'h140;
    @(posedge clk); #1;
    chk("wb_mm_req", 128'(mm_req), 1);
    chk("wb_mm_we", 128'(mm_we), 1);
    chk("wb_mm_addr", 128'(mm_addr), 128'(32'h40));
    chk("wb_mm_wdata0", 128'(mm_wdata[31:0]), 128'(32'hDD));
    reset = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_readdata", 128'(readdata), 0);
    chk("abort_stall", 128'(requested_data_to_mem), 0);
    chk("abort_mm_req", 128'(mm_req), 0);
    chk("abort_mm_we", 128'(mm_we), 0);
    chk("abort_mm_addr", 128'(mm_addr), 0);
    chk("abort_mm_wdata", mm_wdata, 0);
    exp_m(0, 32'h40, 0);
    do_req(1, 0, 32'h40, 0, 0, 32'h41, st);
    chk("abort_miss", 128'(st > 0), 1);
    exp_m(0, 32'h60, 0);
    do_req(0, 1, 32'h60, 32'hEE, 1, 0, st);
    do_req(1, 0, 32'h60, 0, 0, 32'hEE, st);
    chk("replayed_store_hit", 128'(st), 0);
    do_req(1, 0, 32'h64, 0, 0, 32'h62, st);
    chk("mm_queue_empty", 128'(exp_mm.size()), 0);
    chk("rd_queue_empty", 128'(exp_rd.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
